vm1_regbank: RTL and testbench

- Parametrised general-register file for the next-generation VM1-family core.
- Generalises the fixed 8×16 register array into:
  - configurable width and register count;
  - multiple banked register sets, selected by a mode input;
  - dual read ports;
  - PC/SP auto-increment ports.
- Adds a bus-mastering save/restore engine that moves one bank to or from memory for context switches.
- Sits between the microcode control word decode and the ALU/bus muxes in the datapath.

---
 rtl/vm1_pkg.sv | 25 ++
 rtl/vm1_regbank_xfer.sv | 102 ++++++++++
 rtl/vm1_regbank.sv | 149 ++++++++++++++
 tb/tb_vm1_regbank.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vm1_pkg.sv
// Shared types and index helpers for the VM1 register bank and its transfer engine.
// Pure declarations: no logic, no latency, no flow control.
package vm1_pkg;

  typedef enum logic [1:0] {
    XFER_IDLE = 2'd0,
    XFER_REQ  = 2'd1,
    XFER_WAIT = 2'd2,
    XFER_DONE = 2'd3
  } xfer_state_e;

  function automatic int pc_idx(input int nreg);
    return nreg - 1;
  endfunction

  function automatic int sp_idx(input int nreg);
    return nreg - 2;
  endfunction

  // A single bank still gets a one-bit select so port widths never collapse to zero.
  function automatic int bank_w(input int nbank);
    return (nbank > 1) ? $clog2(nbank) : 1;
  endfunction

endpackage

// File: rtl/vm1_regbank_xfer.sv
// Bank save/restore bus master: walks registers 0..NREG-2 of one bank to/from memory.
// Two cycles per word minimum (REQ then WAIT); stalls in WAIT until bus_ack, frozen while ce is low.
module vm1_regbank_xfer
  import vm1_pkg::*;
#(
  parameter int W    = 16,
  parameter int NREG = 8,
  parameter int BW   = 1,
  parameter int IW   = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  input  logic          xfer_start,
  input  logic          xfer_load,
  input  logic [BW-1:0] xfer_bank,
  input  logic [W-1:0]  xfer_base,
  input  logic [W-1:0]  save_data,
  input  logic [W-1:0]  bus_rdata,
  input  logic          bus_ack,
  output logic [BW-1:0] bank,
  output logic [IW-1:0] idx,
  output logic          bus_req,
  output logic          bus_we,
  output logic [W-1:0]  bus_addr,
  output logic [W-1:0]  bus_wdata,
  output logic          busy,
  output logic          done,
  output logic          arr_wr_en,
  output logic [W-1:0]  arr_wr_data
);

  xfer_state_e   state_q, state_d;
  logic          load_q, load_d;
  logic [BW-1:0] bank_q, bank_d;
  logic [W-1:0]  base_q, base_d;
  logic [IW-1:0] idx_q, idx_d;

  always_comb begin
    state_d   = state_q;
    load_d    = load_q;
    bank_d    = bank_q;
    base_d    = base_q;
    idx_d     = idx_q;
    arr_wr_en = 1'b0;
    if (ce) begin
      case (state_q)
        XFER_IDLE: begin
          if (xfer_start) begin
            state_d = XFER_REQ;
            load_d  = xfer_load;
            bank_d  = xfer_bank;
            base_d  = xfer_base & ~W'(1);
            idx_d   = '0;
          end
        end
        XFER_REQ: state_d = XFER_WAIT;
        XFER_WAIT: begin
          if (bus_ack) begin
            arr_wr_en = load_q;
            if (idx_q == IW'(NREG - 2)) begin
              state_d = XFER_DONE;
            end else begin
              idx_d   = idx_q + IW'(1);
              state_d = XFER_REQ;
            end
          end
        end
        XFER_DONE: state_d = XFER_IDLE;
        default:   state_d = XFER_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= XFER_IDLE;
      load_q  <= 1'b0;
      bank_q  <= '0;
      base_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      bank_q  <= bank_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
    end
  end

  // Bus outputs derive from held state, so they stay stable through WAIT and while ce is low.
  assign bus_req     = (state_q == XFER_REQ) || (state_q == XFER_WAIT);
  assign bus_we      = bus_req && !load_q;
  assign bus_addr    = bus_req ? base_q + W'({idx_q, 1'b0}) : '0;
  assign bus_wdata   = bus_we ? save_data : '0;
  assign busy        = bus_req;
  assign done        = (state_q == XFER_DONE);
  assign bank        = bank_q;
  assign idx         = idx_q;
  assign arr_wr_data = bus_rdata;

endmodule

// File: rtl/vm1_regbank.sv
// Banked general-register file with shared PC, dual combinational reads and PC/SP auto-increment.
// Writes land next edge; core writes to a bank being transferred are dropped and flagged via conflict.
module vm1_regbank
  import vm1_pkg::*;
#(
  parameter int W      = 16,
  parameter int NREG   = 8,
  parameter int NBANK  = 2,
  parameter int BYPASS = 1,
  localparam int BW    = bank_w(NBANK),
  localparam int IW    = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  input  logic [BW-1:0] bank_sel,
  input  logic [IW-1:0] rd_a_idx,
  input  logic [IW-1:0] rd_b_idx,
  output logic [W-1:0]  rd_a_data,
  output logic [W-1:0]  rd_b_data,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [W-1:0]  wr_data,
  input  logic          pc_inc2,
  input  logic          sp_inc2,
  input  logic          sp_dec2,
  output logic [W-1:0]  pc_out,
  output logic [W-1:0]  sp_out,
  input  logic          xfer_start,
  input  logic          xfer_load,
  input  logic [BW-1:0] xfer_bank,
  input  logic [W-1:0]  xfer_base,
  output logic          bus_req,
  output logic          bus_we,
  output logic [W-1:0]  bus_addr,
  output logic [W-1:0]  bus_wdata,
  input  logic [W-1:0]  bus_rdata,
  input  logic          bus_ack,
  output logic          busy,
  output logic          done,
  output logic          conflict
);

  localparam int PC_IDX = pc_idx(NREG);
  localparam int SP_IDX = sp_idx(NREG);
  localparam int NB     = NREG - 1;

  logic [W-1:0]  regs_q [NBANK][NB];
  logic [W-1:0]  regs_d [NBANK][NB];
  logic [W-1:0]  pc_q, pc_d;

  logic [BW-1:0] x_bank;
  logic [IW-1:0] x_idx;
  logic          x_wr_en;
  logic [W-1:0]  x_wr_data;
  logic [W-1:0]  x_save_data;
  logic          core_ok;
  logic          sp_step;

  function automatic logic [W-1:0] bank_reg(input logic [BW-1:0] b, input logic [IW-1:0] r);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < NBANK; i++)
      for (int j = 0; j < NB; j++)
        if (b == BW'(i) && r == IW'(j)) v = regs_q[i][j];
    return v;
  endfunction

  function automatic logic [W-1:0] read_port(input logic [IW-1:0] r);
    if (BYPASS != 0 && wr_en && wr_idx == r) return wr_data;
    if (r == IW'(PC_IDX)) return pc_q;
    return bank_reg(bank_sel, r);
  endfunction

  always_comb begin
    rd_a_data   = read_port(rd_a_idx);
    rd_b_data   = read_port(rd_b_idx);
    sp_out      = bank_reg(bank_sel, IW'(SP_IDX));
    x_save_data = bank_reg(x_bank, x_idx);
  end

  assign pc_out  = pc_q;
  assign core_ok = !(busy && bank_sel == x_bank);
  assign sp_step = sp_inc2 ^ sp_dec2;
  // The shared PC is never part of a transfer, so PC writes are never a conflict.
  assign conflict = ce && !core_ok && ((wr_en && wr_idx != IW'(PC_IDX)) || sp_step);

  always_comb begin
    regs_d = regs_q;
    pc_d   = pc_q;
    if (ce) begin
      if (wr_en && wr_idx == IW'(PC_IDX)) pc_d = wr_data;
      else if (pc_inc2)                   pc_d = pc_q + W'(2);
      for (int b = 0; b < NBANK; b++) begin
        for (int r = 0; r < NB; r++) begin
          if (x_wr_en && x_bank == BW'(b) && x_idx == IW'(r)) begin
            regs_d[b][r] = x_wr_data;
          end else if (core_ok && bank_sel == BW'(b)) begin
            if (wr_en && wr_idx == IW'(r))
              regs_d[b][r] = wr_data;
            else if (r == SP_IDX && sp_step)
              regs_d[b][r] = sp_inc2 ? regs_q[b][r] + W'(2) : regs_q[b][r] - W'(2);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= '0;
      for (int b = 0; b < NBANK; b++)
        for (int r = 0; r < NB; r++) regs_q[b][r] <= '0;
    end else begin
      pc_q <= pc_d;
      for (int b = 0; b < NBANK; b++)
        for (int r = 0; r < NB; r++) regs_q[b][r] <= regs_d[b][r];
    end
  end

  vm1_regbank_xfer #(
    .W    (W),
    .NREG (NREG),
    .BW   (BW),
    .IW   (IW)
  ) u_xfer (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce          (ce),
    .xfer_start  (xfer_start),
    .xfer_load   (xfer_load),
    .xfer_bank   (xfer_bank),
    .xfer_base   (xfer_base),
    .save_data   (x_save_data),
    .bus_rdata   (bus_rdata),
    .bus_ack     (bus_ack),
    .bank        (x_bank),
    .idx         (x_idx),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .busy        (busy),
    .done        (done),
    .arr_wr_en   (x_wr_en),
    .arr_wr_data (x_wr_data)
  );

endmodule

// File: tb/tb_vm1_regbank.sv
// Directed bench for vm1_regbank (W=16, NREG=8, NBANK=2, BYPASS=1): R6 is SP, R7 is the shared PC.
module tb_vm1_regbank;

  logic        clk;
  logic        reset_n;
  logic        ce;
  logic [0:0]  bank_sel;
  logic [2:0]  rd_a_idx, rd_b_idx;
  logic [15:0] rd_a_data, rd_b_data;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [15:0] wr_data;
  logic        pc_inc2, sp_inc2, sp_dec2;
  logic [15:0] pc_out, sp_out;
  logic        xfer_start, xfer_load;
  logic [0:0]  xfer_bank;
  logic [15:0] xfer_base;
  logic        bus_req, bus_we;
  logic [15:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack, busy, done, conflict;

  int n_tests = 0;
  int n_fail  = 0;

  vm1_regbank #(.W(16), .NREG(8), .NBANK(2), .BYPASS(1)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .bank_sel(bank_sel),
    .rd_a_idx(rd_a_idx), .rd_b_idx(rd_b_idx), .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .pc_inc2(pc_inc2), .sp_inc2(sp_inc2), .sp_dec2(sp_dec2), .pc_out(pc_out), .sp_out(sp_out),
    .xfer_start(xfer_start), .xfer_load(xfer_load), .xfer_bank(xfer_bank), .xfer_base(xfer_base),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .busy(busy), .done(done), .conflict(conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic b, input logic [2:0] i, input logic [15:0] d);
    bank_sel = b;
    wr_en    = 1'b1;
    wr_idx   = i;
    wr_data  = d;
    @(negedge clk);
    wr_en    = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [2:0] i, input logic [15:0] exp);
    rd_a_idx = i;
    #1;
    check(tag, {16'h0, rd_a_data}, {16'h0, exp});
    @(negedge clk);
  endtask

  // Acts as the memory for one word: bounded wait for bus_req, check the request, ack after 1-3 cycles.
  task automatic xfer_word(input logic exp_we, input logic [15:0] exp_addr,
                           input logic [15:0] exp_wdata, input logic [15:0] rdata);
    int t;
    int waits;
    t = 0;
    while (bus_req !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("bus_req_seen", {31'h0, bus_req}, 32'h1);
    check("bus_addr", {16'h0, bus_addr}, {16'h0, exp_addr});
    check("bus_we", {31'h0, bus_we}, {31'h0, exp_we});
    check("busy_in_xfer", {31'h0, busy}, 32'h1);
    if (exp_we) check("bus_wdata", {16'h0, bus_wdata}, {16'h0, exp_wdata});
    waits = int'($urandom_range(1, 3));
    repeat (waits) @(negedge clk);
    check("bus_addr_held", {16'h0, bus_addr}, {16'h0, exp_addr});
    bus_rdata = rdata;
    bus_ack   = 1'b1;
    @(negedge clk);
    bus_ack   = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b1; bank_sel = '0; rd_a_idx = '0; rd_b_idx = '0;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0; pc_inc2 = 1'b0; sp_inc2 = 1'b0; sp_dec2 = 1'b0;
    xfer_start = 1'b0; xfer_load = 1'b0; xfer_bank = '0; xfer_base = '0;
    bus_rdata = '0; bus_ack = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset clears previously written state, including the PC
    wr(1'b0, 3'd0, 16'h1234);
    wr(1'b0, 3'd7, 16'h0055);
    rd_check("pre_reset_r0", 3'd0, 16'h1234);
    check("pre_reset_pc", {16'h0, pc_out}, 32'h55);
    reset_n = 1'b0;
    rd_a_idx = 3'd0;
    #1;
    check("reset_r0", {16'h0, rd_a_data}, 32'h0);
    check("reset_pc", {16'h0, pc_out}, 32'h0);
    check("reset_bus_req", {31'h0, bus_req}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Banking and the shared PC
    wr(1'b0, 3'd3, 16'o123456);
    wr(1'b1, 3'd3, 16'o7);
    bank_sel = 1'b0;
    rd_check("bank0_r3", 3'd3, 16'o123456);
    bank_sel = 1'b1;
    rd_check("bank1_r3", 3'd3, 16'o7);
    wr(1'b1, 3'd7, 16'o4444);
    bank_sel = 1'b0;
    rd_check("pc_shared", 3'd7, 16'o4444);

    // PC / SP wrap and write priority
    wr(1'b0, 3'd7, 16'o177776);
    pc_inc2 = 1'b1;
    @(negedge clk);
    pc_inc2 = 1'b0;
    check("pc_wrap", {16'h0, pc_out}, 32'h0);
    wr(1'b0, 3'd6, 16'h0);
    sp_dec2 = 1'b1;
    @(negedge clk);
    sp_dec2 = 1'b0;
    check("sp_wrap", {16'h0, sp_out}, {16'h0, 16'o177776});
    sp_dec2 = 1'b1;
    wr(1'b0, 3'd6, 16'o1000);
    sp_dec2 = 1'b0;
    check("wr_beats_dec", {16'h0, sp_out}, {16'h0, 16'o1000});
    sp_inc2 = 1'b1; sp_dec2 = 1'b1;
    @(negedge clk);
    sp_inc2 = 1'b0; sp_dec2 = 1'b0;
    check("sp_inc_dec_both", {16'h0, sp_out}, {16'h0, 16'o1000});
    sp_inc2 = 1'b1;
    @(negedge clk);
    sp_inc2 = 1'b0;
    check("sp_inc", {16'h0, sp_out}, {16'h0, 16'o1002});

    // Same-cycle bypass on one port, plain read on the other
    bank_sel = 1'b0; wr_en = 1'b1; wr_idx = 3'd2; wr_data = 16'hBEEF;
    rd_a_idx = 3'd2; rd_b_idx = 3'd3;
    #1;
    check("bypass_a", {16'h0, rd_a_data}, 32'hBEEF);
    check("no_bypass_b", {16'h0, rd_b_data}, {16'h0, 16'o123456});
    @(negedge clk);
    wr_en = 1'b0;

    // Clock enable low freezes writes and increments
    ce = 1'b0; wr_en = 1'b1; wr_idx = 3'd2; wr_data = 16'h1111; pc_inc2 = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; pc_inc2 = 1'b0; ce = 1'b1;
    check("ce_pc_frozen", {16'h0, pc_out}, 32'h0);
    rd_check("ce_r2_frozen", 3'd2, 16'hBEEF);

    // Save bank 1 (R0..R6 = 1..7) to an odd base, which is forced even
    for (int r = 0; r < 7; r++) wr(1'b1, 3'(r), 16'(r + 1));
    xfer_start = 1'b1; xfer_load = 1'b0; xfer_bank = 1'b1; xfer_base = 16'o1001;
    @(negedge clk);
    check("save_busy_start", {31'h0, busy}, 32'h1);
    xfer_load = 1'b1; xfer_bank = 1'b0;
    @(negedge clk);
    xfer_start = 1'b0;
    for (int k = 0; k < 7; k++)
      xfer_word(1'b1, 16'o1000 + 16'(2 * k), 16'(k + 1), 16'h0);
    check("save_done", {31'h0, done}, 32'h1);
    check("save_busy_end", {31'h0, busy}, 32'h0);
    check("save_req_end", {31'h0, bus_req}, 32'h0);
    @(negedge clk);
    check("save_done_once", {31'h0, done}, 32'h0);

    // Load bank 0 while the core writes R1 of each bank
    xfer_start = 1'b1; xfer_load = 1'b1; xfer_bank = 1'b0; xfer_base = 16'o2000;
    @(negedge clk);
    xfer_start = 1'b0;
    bank_sel = 1'b0; wr_en = 1'b1; wr_idx = 3'd1; wr_data = 16'h5555;
    #1;
    check("conflict_bank0", {31'h0, conflict}, 32'h1);
    @(negedge clk);
    bank_sel = 1'b1; wr_data = 16'h6666;
    #1;
    check("no_conflict_bank1", {31'h0, conflict}, 32'h0);
    @(negedge clk);
    wr_en = 1'b0; bank_sel = 1'b0;
    for (int k = 0; k < 7; k++)
      xfer_word(1'b0, 16'o2000 + 16'(2 * k), 16'h0, 16'hA000 + 16'(k));
    check("load_done", {31'h0, done}, 32'h1);
    @(negedge clk);
    bank_sel = 1'b0;
    for (int r = 0; r < 7; r++) rd_check("load_data", 3'(r), 16'hA000 + 16'(r));
    bank_sel = 1'b1;
    rd_check("bank1_r1_kept", 3'd1, 16'h6666);

    // Reset in the middle of a load aborts without a done pulse
    xfer_start = 1'b1; xfer_load = 1'b1; xfer_bank = 1'b1; xfer_base = 16'o3000;
    @(negedge clk);
    xfer_start = 1'b0;
    xfer_word(1'b0, 16'o3000, 16'h0, 16'h1);
    xfer_word(1'b0, 16'o3002, 16'h0, 16'h2);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_bus_req", {31'h0, bus_req}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_no_done", {30'h0, done, bus_req}, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
